ps2_game_input: RTL and testbench
=================================

# ps2_game_input

PS/2 keyboard front end for the game core: receives PS/2 device-to-host frames, decodes Set-2 make/break scan codes, and produces the game's user-input signals. These are the start pulse, 2-bit direction, attack pulse and defend hold. The block sits between the board PS/2 connector and the game controller's `i_start/i_dir/i_attack/i_defend` inputs, in the game's `clk` domain.

## Interface
- `FRAME_TIMEOUT`, 50000: `clk` cycles without a PS/2 falling edge before a partial frame is aborted (1 ms at 50 MHz).
- `TO_WIDTH`, 16: timeout counter width; must hold `FRAME_TIMEOUT`.

- `clk` in 1: game clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `i_ps2_clk` in 1: raw PS/2 clock pin, asynchronous.
- `i_ps2_data` in 1: raw PS/2 data pin, asynchronous.
- `o_start` out 1: one-cycle pulse on Enter press.
- `o_dir` out 2: direction; 00=up, 01=right, 10=down, 11=left.
- `o_move` out 1: level, high while any direction key is held.
- `o_attack` out 1: one-cycle pulse on J press.
- `o_defend` out 1: level, high while K is held.
- `o_frame_err` out 1: one-cycle pulse on a parity, stop or timeout error.

## Operation
- **Synchronizer:** 2-FF on both pins. A falling edge is detected in the first cycle where the synced clock is 0 and its previous value was 1. Bits are sampled from synced data in that cycle.
- **Receiver FSM** (IDLE → DATA → PARITY → STOP → IDLE):
  - IDLE: on an edge with data=0, go to DATA with bit count 0. Data=1 in IDLE is ignored.
  - DATA: shift 8 bits, LSB first.
  - PARITY: sample the parity bit.
  - STOP: require stop=1 and odd parity across the 8 data bits plus the parity bit. Pass → `byte_valid` for 1 cycle with the byte. Fail → `o_frame_err`, byte discarded.
- **Timeout:** the counter clears on every edge and counts while not in IDLE. When it reaches `FRAME_TIMEOUT`, go to IDLE and pulse `o_frame_err`.
- **Decoder prefixes:** E0 sets `ext`; F0 sets `brk`. Any other byte is looked up with `ext`, applied as make (brk=0) or break (brk=1), then both flags clear. Unknown codes are ignored and also clear the flags. A frame error clears both flags.
- **Key map:**
  - Up: 1D (W) or E0 75.
  - Right: 23 (D) or E0 74.
  - Down: 1B (S) or E0 72.
  - Left: 1C (A) or E0 6B.
  - Attack: 3B (J). Defend: 42 (K). Start: 5A, with or without E0.
- **Held state:** one held bit per physical key; the letter and the arrow for the same direction are separate bits. A direction counts as held if either of its keys is held.
- **Typematic repeats:** a make for a key already held is a no-op. `o_attack` and `o_start` pulse only on a not-held → held transition.
- **Direction priority:**
  - Make of a direction key → `o_dir` = that direction.
  - Break of the current `o_dir` direction with other directions still held → `o_dir` = lowest-encoded held direction.
  - No direction held → `o_move`=0 and `o_dir` keeps its last value.
- **Reset:** all outputs 0, `o_dir`=00, FSM IDLE, all held bits and flags cleared. Reset mid-frame discards the partial frame with no `o_frame_err`.

## Timing
- Pin to synced value: 2 cycles. Edge detect: +1 cycle (cycle E).
- Stop bit sampled in cycle E. `byte_valid` is high in E+1. Decoded outputs change in E+2.
- `o_frame_err` is high in E+1 for parity/stop errors. For timeout it is high in the cycle after the counter hits `FRAME_TIMEOUT`.
- All outputs are registered; pulses are exactly 1 `clk` cycle.
- The receiver FSM is never blocked. Frames arrive at least ~1 ms apart, so the decoder never sees back-to-back `byte_valid`.

## Structure
- Package `ps2_game_pkg` holds:
  - scan-code localparams (`SC_W`, `SC_UP_EXT`, `SC_ENTER`, `SC_J`, `SC_K`, `SC_E0`, `SC_F0`, …);
  - direction encodings `DIR_UP..DIR_LEFT`;
  - receiver state enum.
- Sub-module `ps2_rx` contains the synchronizer, edge detect, receiver FSM and timeout, with outputs `byte_valid`, `byte_data[7:0]` and `frame_err`.
- Top level `ps2_game_input` contains the prefix tracking, held bits, pulse generation and direction priority.

## Test plan
- Frame 1D → in E+2, `o_move`=1 and `o_dir`=00. Then F0, 1D → `o_move`=0 and `o_dir` stays 00.
- E0 74, then three repeats of E0 74 → `o_dir`=01 and `o_move`=1 throughout, no glitch. Then E0 F0 74 → `o_move`=0.
- 3B → one `o_attack` pulse. Repeat 3B → no pulse. F0 3B, then 3B → a second pulse. 5A → one `o_start` pulse.
- Byte 42 with wrong parity → `o_frame_err` pulse in E+1 and `o_defend` stays 0. Next valid 42 → `o_defend`=1. Then F0 42 → 0.
- Send start bit plus 4 data bits, then idle for `FRAME_TIMEOUT` cycles → one `o_frame_err` pulse. Following valid 5A → `o_start` pulse.
- 1C, then 23 → `o_dir` 11 then 01. F0 23 → `o_dir`=11 and `o_move`=1. Assert `rst` mid-frame → all outputs 0, and the next valid frame decodes normally.

Source files
------------

// File: rtl/ps2_game_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ps2_game_pkg
// Purpose : Shared constants for the PS/2 game input front end. Holds the
//           Set-2 scan codes, the direction encoding, the held-key indices,
//           the receiver state type and the scan-code lookup helpers.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package ps2_game_pkg;

  // Set-2 scan codes
  localparam logic [7:0] SC_E0        = 8'hE0;
  localparam logic [7:0] SC_F0        = 8'hF0;
  localparam logic [7:0] SC_W         = 8'h1D;
  localparam logic [7:0] SC_D         = 8'h23;
  localparam logic [7:0] SC_S         = 8'h1B;
  localparam logic [7:0] SC_A         = 8'h1C;
  localparam logic [7:0] SC_UP_EXT    = 8'h75;
  localparam logic [7:0] SC_RIGHT_EXT = 8'h74;
  localparam logic [7:0] SC_DOWN_EXT  = 8'h72;
  localparam logic [7:0] SC_LEFT_EXT  = 8'h6B;
  localparam logic [7:0] SC_J         = 8'h3B;
  localparam logic [7:0] SC_K         = 8'h42;
  localparam logic [7:0] SC_ENTER     = 8'h5A;

  // Direction encoding presented on o_dir
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  // Held-key indices. The eight direction keys come first and their low two
  // bits equal the DIR_* code of the direction they steer, so a direction
  // key's direction is simply idx[1:0].
  localparam int         NUM_KEYS     = 12;
  localparam logic [3:0] KEY_W        = 4'd0;
  localparam logic [3:0] KEY_D        = 4'd1;
  localparam logic [3:0] KEY_S        = 4'd2;
  localparam logic [3:0] KEY_A        = 4'd3;
  localparam logic [3:0] KEY_UP_X     = 4'd4;
  localparam logic [3:0] KEY_RIGHT_X  = 4'd5;
  localparam logic [3:0] KEY_DOWN_X   = 4'd6;
  localparam logic [3:0] KEY_LEFT_X   = 4'd7;
  localparam logic [3:0] KEY_J        = 4'd8;
  localparam logic [3:0] KEY_K        = 4'd9;
  localparam logic [3:0] KEY_ENTER    = 4'd10;
  localparam logic [3:0] KEY_ENTER_X  = 4'd11;
  localparam logic [3:0] NUM_DIR_KEYS = 4'd8;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } key_hit_t;

  // Map a (prefix, code) pair onto a held-key index.
  function automatic key_hit_t key_lookup(input logic ext, input logic [7:0] code);
    key_hit_t r;
    r.hit = 1'b1;
    r.idx = KEY_W;
    if (!ext) begin
      case (code)
        SC_W:     r.idx = KEY_W;
        SC_D:     r.idx = KEY_D;
        SC_S:     r.idx = KEY_S;
        SC_A:     r.idx = KEY_A;
        SC_J:     r.idx = KEY_J;
        SC_K:     r.idx = KEY_K;
        SC_ENTER: r.idx = KEY_ENTER;
        default:  r.hit = 1'b0;
      endcase
    end else begin
      case (code)
        SC_UP_EXT:    r.idx = KEY_UP_X;
        SC_RIGHT_EXT: r.idx = KEY_RIGHT_X;
        SC_DOWN_EXT:  r.idx = KEY_DOWN_X;
        SC_LEFT_EXT:  r.idx = KEY_LEFT_X;
        SC_ENTER:     r.idx = KEY_ENTER_X;
        default:      r.hit = 1'b0;
      endcase
    end
    return r;
  endfunction

  // One bit per direction, set when the letter or the arrow key is held.
  function automatic logic [3:0] dirs_held(input logic [NUM_KEYS-1:0] held);
    logic [3:0] d;
    d[DIR_UP]    = held[KEY_W] | held[KEY_UP_X];
    d[DIR_RIGHT] = held[KEY_D] | held[KEY_RIGHT_X];
    d[DIR_DOWN]  = held[KEY_S] | held[KEY_DOWN_X];
    d[DIR_LEFT]  = held[KEY_A] | held[KEY_LEFT_X];
    return d;
  endfunction

  function automatic logic [1:0] lowest_dir(input logic [3:0] d);
    logic [1:0] r;
    if (d[DIR_UP])         r = DIR_UP;
    else if (d[DIR_RIGHT]) r = DIR_RIGHT;
    else if (d[DIR_DOWN])  r = DIR_DOWN;
    else                   r = DIR_LEFT;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_game_input_rx.sv
`default_nettype none
// ============================================================================
// Module  : ps2_rx
// Purpose : PS/2 device-to-host frame receiver. Synchronises both pins,
//           detects PS/2 clock falling edges, shifts in start/8 data/parity/
//           stop and checks odd parity and the stop bit. A frame stalled for
//           FRAME_TIMEOUT clk cycles is abandoned.
// Ports   : clk, rst          - game clock, synchronous active-high reset
//           ps2_clk_i         - raw PS/2 clock pin (asynchronous)
//           ps2_data_i        - raw PS/2 data pin (asynchronous)
//           byte_valid_o      - 1-cycle strobe, byte_data_o holds the byte
//           byte_data_o[7:0]  - last good byte
//           frame_err_o       - 1-cycle strobe on parity/stop/timeout error
// Rev     : 1.0  initial release
// ============================================================================
module ps2_rx
  import ps2_game_pkg::*;
#(
  parameter int FRAME_TIMEOUT = 50000,
  parameter int TO_WIDTH      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_o
);

  localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(FRAME_TIMEOUT);
  localparam logic [TO_WIDTH-1:0] TO_ONE   = TO_WIDTH'(1);

  logic                clk_s1_q, clk_s2_q, clk_prev_q;
  logic                dat_s1_q, dat_s2_q;
  logic                fall;
  rx_state_e           state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          data_q, data_d;
  logic                par_q, par_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic [TO_WIDTH-1:0] to_cnt_q, to_cnt_d;

  // First cycle in which the synchronised PS/2 clock reads low after high.
  assign fall = clk_prev_q & ~clk_s2_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    to_cnt_d  = '0;
    if (fall) begin
      case (state_q)
        RX_IDLE: begin
          // A high data line here is line noise, not a start bit.
          if (!dat_s2_q) begin
            state_d   = RX_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        RX_DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_d   = dat_s2_q;
          state_d = RX_STOP;
        end
        default: begin
          state_d = RX_IDLE;
          if (dat_s2_q && (^{shift_q, par_q})) begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end else begin
            err_d = 1'b1;
          end
        end
      endcase
    end else if (state_q != RX_IDLE) begin
      if (to_cnt_q == TO_LIMIT) begin
        state_d = RX_IDLE;
        err_d   = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Pins idle high; presetting the synchroniser avoids a false edge.
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      state_q    <= RX_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      data_q     <= 8'd0;
      par_q      <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      to_cnt_q   <= '0;
    end else begin
      clk_s1_q   <= ps2_clk_i;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data_i;
      dat_s2_q   <= dat_s1_q;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      par_q      <= par_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign byte_valid_o = valid_q;
  assign byte_data_o  = data_q;
  assign frame_err_o  = err_q;

endmodule
`default_nettype wire

// File: rtl/ps2_game_input.sv
`default_nettype none
// ============================================================================
// Module  : ps2_game_input
// Purpose : PS/2 keyboard front end for the game core. Decodes Set-2
//           make/break codes (E0/F0 prefixes) into held-key state and drives
//           the game's start/direction/attack/defend inputs.
// Ports   : clk, rst      - game clock, synchronous active-high reset
//           i_ps2_clk     - raw PS/2 clock pin
//           i_ps2_data    - raw PS/2 data pin
//           o_start       - 1-cycle pulse on Enter press
//           o_dir[1:0]    - 00 up, 01 right, 10 down, 11 left
//           o_move        - high while any direction key is held
//           o_attack      - 1-cycle pulse on J press
//           o_defend      - high while K is held
//           o_frame_err   - 1-cycle pulse on parity/stop/timeout error
// Rev     : 1.0  initial release
// ============================================================================
module ps2_game_input
  import ps2_game_pkg::*;
#(
  parameter int FRAME_TIMEOUT = 50000,
  parameter int TO_WIDTH      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic       o_start,
  output logic [1:0] o_dir,
  output logic       o_move,
  output logic       o_attack,
  output logic       o_defend,
  output logic       o_frame_err
);

  logic                rx_valid;
  logic [7:0]          rx_byte;
  logic                rx_err;
  key_hit_t            key_hit;
  logic                is_dir_key;

  logic [NUM_KEYS-1:0] held_q, held_d;
  logic [1:0]          dir_q, dir_d;
  logic                ext_q, ext_d;
  logic                brk_q, brk_d;
  logic                start_q, start_d;
  logic                attack_q, attack_d;
  logic                move_q, move_d;
  logic                rel_dir;
  logic [3:0]          dir_held_d;

  ps2_rx #(
    .FRAME_TIMEOUT (FRAME_TIMEOUT),
    .TO_WIDTH      (TO_WIDTH)
  ) u_rx (
    .clk          (clk),
    .rst          (rst),
    .ps2_clk_i    (i_ps2_clk),
    .ps2_data_i   (i_ps2_data),
    .byte_valid_o (rx_valid),
    .byte_data_o  (rx_byte),
    .frame_err_o  (rx_err)
  );

  assign key_hit    = key_lookup(ext_q, rx_byte);
  assign is_dir_key = (key_hit.idx < NUM_DIR_KEYS);

  always_comb begin
    held_d     = held_q;
    dir_d      = dir_q;
    ext_d      = ext_q;
    brk_d      = brk_q;
    start_d    = 1'b0;
    attack_d   = 1'b0;
    rel_dir    = 1'b0;
    dir_held_d = 4'd0;
    move_d     = 1'b0;
    if (rx_err) begin
      // A lost byte may have been a prefix; drop any half-built sequence.
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == SC_E0) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_F0) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (key_hit.hit) begin
          if (!brk_q && !held_q[key_hit.idx]) begin
            // Only a genuine press acts; typematic repeats fall through.
            held_d[key_hit.idx] = 1'b1;
            attack_d = (key_hit.idx == KEY_J);
            start_d  = (key_hit.idx == KEY_ENTER) || (key_hit.idx == KEY_ENTER_X);
            if (is_dir_key) dir_d = key_hit.idx[1:0];
          end else if (brk_q && held_q[key_hit.idx]) begin
            held_d[key_hit.idx] = 1'b0;
            rel_dir = is_dir_key;
          end
        end
      end
    end
    dir_held_d = dirs_held(held_d);
    move_d     = |dir_held_d;
    // Releasing the steering direction hands over to the lowest-coded
    // direction still held; with nothing held o_dir keeps its last value.
    if (rel_dir && !dir_held_d[dir_q] && move_d) dir_d = lowest_dir(dir_held_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_q   <= '0;
      dir_q    <= DIR_UP;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      start_q  <= 1'b0;
      attack_q <= 1'b0;
      move_q   <= 1'b0;
    end else begin
      held_q   <= held_d;
      dir_q    <= dir_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      start_q  <= start_d;
      attack_q <= attack_d;
      move_q   <= move_d;
    end
  end

  assign o_start     = start_q;
  assign o_dir       = dir_q;
  assign o_move      = move_q;
  assign o_attack    = attack_q;
  assign o_defend    = held_q[KEY_K];
  assign o_frame_err = rx_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_game_input.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_ps2_game_input
// Purpose : Self-checking bench for ps2_game_input: directed vector table,
//           cycle-exact corner sequences and randomised key traffic checked
//           against a key-level behavioural model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_ps2_game_input;

  localparam int TO   = 300;
  localparam int HALF = 6;
  localparam int GAP  = 20;
  localparam int K_DIR = 0, K_ATT = 1, K_DEF = 2, K_START = 3;

  logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic       o_start, o_move, o_attack, o_defend, o_frame_err;
  logic [1:0] o_dir;

  ps2_game_input #(.FRAME_TIMEOUT(TO), .TO_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .i_ps2_clk(ps2_clk), .i_ps2_data(ps2_data),
    .o_start(o_start), .o_dir(o_dir), .o_move(o_move), .o_attack(o_attack),
    .o_defend(o_defend), .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int n_start = 0, n_attack = 0, n_err = 0;
  logic smp_err [1:4];
  logic smp_def [1:4];

  always @(negedge clk) begin
    if (o_start)     n_start++;
    if (o_attack)    n_attack++;
    if (o_frame_err) n_err++;
  end

  // ---------------- behavioural key model ----------------
  typedef struct {logic [7:0] code; bit ext; int kind; int dir;} key_t;
  key_t keys [11];
  bit   m_held [11];
  bit   m_ext, m_brk;
  int   m_dir, e_start, e_attack, e_err;

  function automatic bit m_dir_held(int d);
    for (int i = 0; i < 11; i++)
      if (keys[i].kind == K_DIR && keys[i].dir == d && m_held[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_move();
    for (int d = 0; d < 4; d++) if (m_dir_held(d)) return 1;
    return 0;
  endfunction

  function automatic int m_def();
    for (int i = 0; i < 11; i++) if (keys[i].kind == K_DEF && m_held[i]) return 1;
    return 0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 11; i++) m_held[i] = 1'b0;
    m_ext = 1'b0; m_brk = 1'b0; m_dir = 0;
  endtask

  task automatic m_byte(input logic [7:0] b);
    int k;
    k = -1;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      for (int i = 0; i < 11; i++) if (keys[i].code == b && keys[i].ext == m_ext) k = i;
      if (k >= 0) begin
        if (!m_brk && !m_held[k]) begin
          m_held[k] = 1'b1;
          if (keys[k].kind == K_START) e_start++;
          if (keys[k].kind == K_ATT) e_attack++;
          if (keys[k].kind == K_DIR) m_dir = keys[k].dir;
        end else if (m_brk && m_held[k]) begin
          m_held[k] = 1'b0;
          if (keys[k].kind == K_DIR && !m_dir_held(m_dir)) begin
            for (int d = 3; d >= 0; d--) if (m_dir_held(d)) m_dir = d;
          end
        end
      end
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, " dir"}, int'(o_dir), m_dir);
    check({tag, " move"}, int'(o_move), m_move());
    check({tag, " defend"}, int'(o_defend), m_def());
    check({tag, " start_cnt"}, n_start, e_start);
    check({tag, " attack_cnt"}, n_attack, e_attack);
    check({tag, " err_cnt"}, n_err, e_err);
  endtask

  // Sends nbits of a frame; after the stop-bit fall, samples the outputs on
  // the next four negedges (sample 2 = cycle E).
  task automatic send_bits(input logic [7:0] d, input bit flip, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^d) ^ flip, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) begin
        for (int s = 1; s <= 4; s++) begin
          @(negedge clk);
          smp_err[s] = o_frame_err;
          smp_def[s] = o_defend;
        end
      end
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic apply(input logic [7:0] d, input bit flip);
    send_bits(d, flip, 11);
    if (flip) begin
      e_err++; m_ext = 1'b0; m_brk = 1'b0;
    end else m_byte(d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    ps2_clk = 1'b1; ps2_data = 1'b1; rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
  endtask

  typedef struct {logic [7:0] b0, b1, b2; int n; int dir; int move; int dst; int dat;} vec_t;
  vec_t vt [16];

  initial begin
    int s0, a0, r, ncode;
    logic [7:0] seq [3];
    keys[0]  = '{8'h1D, 1'b0, K_DIR, 0};
    keys[1]  = '{8'h23, 1'b0, K_DIR, 1};
    keys[2]  = '{8'h1B, 1'b0, K_DIR, 2};
    keys[3]  = '{8'h1C, 1'b0, K_DIR, 3};
    keys[4]  = '{8'h75, 1'b1, K_DIR, 0};
    keys[5]  = '{8'h74, 1'b1, K_DIR, 1};
    keys[6]  = '{8'h72, 1'b1, K_DIR, 2};
    keys[7]  = '{8'h6B, 1'b1, K_DIR, 3};
    keys[8]  = '{8'h3B, 1'b0, K_ATT, 0};
    keys[9]  = '{8'h42, 1'b0, K_DEF, 0};
    keys[10] = '{8'h5A, 1'b0, K_START, 0};
    e_start = 0; e_attack = 0; e_err = 0;
    m_reset();

    vt[0]  = '{8'h1D, 8'h00, 8'h00, 1, 0, 1, 0, 0};
    vt[1]  = '{8'hF0, 8'h1D, 8'h00, 2, 0, 0, 0, 0};
    vt[2]  = '{8'hE0, 8'h74, 8'h00, 2, 1, 1, 0, 0};
    vt[3]  = '{8'hE0, 8'h74, 8'h00, 2, 1, 1, 0, 0};
    vt[4]  = '{8'hE0, 8'h74, 8'h00, 2, 1, 1, 0, 0};
    vt[5]  = '{8'hE0, 8'h74, 8'h00, 2, 1, 1, 0, 0};
    vt[6]  = '{8'hE0, 8'hF0, 8'h74, 3, 1, 0, 0, 0};
    vt[7]  = '{8'h3B, 8'h00, 8'h00, 1, 1, 0, 0, 1};
    vt[8]  = '{8'h3B, 8'h00, 8'h00, 1, 1, 0, 0, 0};
    vt[9]  = '{8'hF0, 8'h3B, 8'h00, 2, 1, 0, 0, 0};
    vt[10] = '{8'h3B, 8'h00, 8'h00, 1, 1, 0, 0, 1};
    vt[11] = '{8'h5A, 8'h00, 8'h00, 1, 1, 0, 1, 0};
    vt[12] = '{8'h1C, 8'h00, 8'h00, 1, 3, 1, 0, 0};
    vt[13] = '{8'h23, 8'h00, 8'h00, 1, 1, 1, 0, 0};
    vt[14] = '{8'hF0, 8'h23, 8'h00, 2, 3, 1, 0, 0};
    vt[15] = '{8'hF0, 8'h1C, 8'h00, 2, 3, 0, 0, 0};

    // Reset state
    repeat (4) @(negedge clk);
    check("rst start", int'(o_start), 0);
    check("rst dir", int'(o_dir), 0);
    check("rst move", int'(o_move), 0);
    check("rst attack", int'(o_attack), 0);
    check("rst defend", int'(o_defend), 0);
    check("rst frame_err", int'(o_frame_err), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Directed vector table
    for (int v = 0; v < 16; v++) begin
      s0 = n_start; a0 = n_attack;
      seq[0] = vt[v].b0; seq[1] = vt[v].b1; seq[2] = vt[v].b2;
      for (int j = 0; j < vt[v].n; j++) apply(seq[j], 1'b0);
      check($sformatf("vec%0d dir", v), int'(o_dir), vt[v].dir);
      check($sformatf("vec%0d move", v), int'(o_move), vt[v].move);
      check($sformatf("vec%0d defend", v), int'(o_defend), 0);
      check($sformatf("vec%0d start", v), n_start - s0, vt[v].dst);
      check($sformatf("vec%0d attack", v), n_attack - a0, vt[v].dat);
    end
    check("vec err_cnt", n_err, 0);

    // Parity error: pulse in E+1 only, K stays released
    apply(8'h42, 1'b1);
    check("par err@E", int'(smp_err[2]), 0);
    check("par err@E+1", int'(smp_err[3]), 1);
    check("par err@E+2", int'(smp_err[4]), 0);
    check("par defend", int'(o_defend), 0);
    apply(8'h42, 1'b0);
    check("K defend@E+1", int'(smp_def[3]), 0);
    check("K defend@E+2", int'(smp_def[4]), 1);
    apply(8'hF0, 1'b0);
    apply(8'h42, 1'b0);
    check_state("K release");

    // Timeout on a partial frame, then a normal Enter
    do_reset();
    send_bits(8'h5A, 1'b0, 5);
    repeat (TO + 40) @(negedge clk);
    e_err++;
    check("timeout err_cnt", n_err, e_err);
    apply(8'h5A, 1'b0);
    check_state("after timeout");

    // Reset in the middle of a frame
    apply(8'h1D, 1'b0);
    apply(8'h42, 1'b0);
    check_state("pre midrst");
    send_bits(8'h23, 1'b0, 4);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    check("midrst move", int'(o_move), 0);
    check("midrst defend", int'(o_defend), 0);
    check("midrst dir", int'(o_dir), 0);
    repeat (TO + 40) @(negedge clk);
    check("midrst err_cnt", n_err, e_err);
    apply(8'h1B, 1'b0);
    check_state("post midrst");

    // Randomised key traffic against the model
    do_reset();
    for (int ev = 0; ev < 50; ev++) begin
      r = $urandom_range(0, 12);
      ncode = 0;
      if (r < 11) begin
        if (keys[r].ext) begin seq[ncode] = 8'hE0; ncode++; end
        if ($urandom_range(0, 2) == 0) begin seq[ncode] = 8'hF0; ncode++; end
        seq[ncode] = keys[r].code; ncode++;
      end else if (r == 11) begin
        seq[0] = 8'h15; ncode = 1;
      end else begin
        seq[0] = 8'hE0; seq[1] = 8'h1D; ncode = 2;
      end
      for (int j = 0; j < ncode; j++) apply(seq[j], $urandom_range(0, 11) == 0);
      check_state($sformatf("rnd%0d", ev));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
